// File: rtl/p2s_pkg.sv
// p2s_pkg -- shared types and elaboration helpers for the p2s_stream
// parallel-to-serial converter.
//   p2s_state_e : FSM state encoding (P2S_IDLE, P2S_SHIFT)
//   p2s_beats   : number of LANE-bit beats per WIDTH-bit word
//   p2s_cw      : beat counter width, never less than one bit
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  function automatic int p2s_beats(input int width, input int lane);
    // A zero lane is rejected at elaboration; return 1 so the divide is safe.
    return (lane == 0) ? 1 : width / lane;
  endfunction

  function automatic int p2s_cw(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/p2s_beat_counter.sv
// p2s_beat_counter -- beat index within the word being serialised.
// Ports:
//   clk_sig   : clock, rising edge
//   reset_sig : synchronous reset, active-low
//   inc       : advance to the next beat
//   clear     : return to beat 0 (wins over inc)
//   is_last   : current beat is BEATS-1
module p2s_beat_counter
  import p2s_pkg::*;
#(
  parameter int CW    = 1,
  parameter int BEATS = 1
) (
  input  logic clk_sig,
  input  logic reset_sig,
  input  logic inc,
  input  logic clear,
  output logic is_last
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign is_last = (count == LAST_BEAT);

endmodule

// File: rtl/p2s_stream.sv
// p2s_stream -- flow-controlled parallel-to-serial converter. A WIDTH-bit
// word accepted on the input handshake leaves as WIDTH/LANE beats of LANE
// bits, LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1). Back-to-back
// words stream without a gap beat.
// Ports:
//   clk_sig       : clock, rising edge
//   reset_sig     : synchronous reset, active-low
//   parallel_sig  : word to serialise, sampled on input handshake
//   in_valid_sig  : parallel_sig valid
//   in_ready_sig  : a word can be taken this cycle
//   serial_sig    : current LANE-bit beat
//   out_valid_sig : serial_sig valid
//   out_ready_sig : downstream takes the beat
//   out_last_sig  : current beat is the last of its word
// Optional build macro P2S_UNDERRUN_EN adds:
//   underrun_sig     : sticky, idle-with-ready seen after a completed word
//   underrun_cnt_sig : count of such cycles, saturates at 255
module p2s_stream
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int LANE      = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic [WIDTH-1:0] parallel_sig,
  input  logic             in_valid_sig,
  output logic             in_ready_sig,
  output logic [LANE-1:0]  serial_sig,
  output logic             out_valid_sig,
  input  logic             out_ready_sig,
  output logic             out_last_sig
`ifdef P2S_UNDERRUN_EN
  ,
  output logic             underrun_sig,
  output logic [7:0]       underrun_cnt_sig
`endif
);

  localparam int BEATS = p2s_beats(WIDTH, LANE);
  localparam int CW    = p2s_cw(BEATS);

  generate
    if (LANE < 1) begin : g_bad_lane
      $error("p2s_stream: LANE must be at least 1");
    end else if (WIDTH < 1) begin : g_bad_width
      $error("p2s_stream: WIDTH must be at least 1");
    end else if ((WIDTH % LANE) != 0) begin : g_bad_ratio
      $error("p2s_stream: WIDTH must be a multiple of LANE");
    end
  endgenerate

  p2s_state_e       state;
  logic [WIDTH-1:0] shift_buf;
  logic [WIDTH-1:0] shifted;
  logic             valid_q;
  logic             cnt_last;
  logic             in_fire;
  logic             out_fire;
  logic             word_end;

  // valid_q mirrors state==P2S_SHIFT as a registered output.
  assign out_valid_sig = valid_q;
  assign out_last_sig  = valid_q && cnt_last;
  assign in_ready_sig  = reset_sig &&
                         ((state == P2S_IDLE) || (out_last_sig && out_ready_sig));
  assign in_fire       = in_valid_sig && in_ready_sig;
  assign out_fire      = valid_q && out_ready_sig;
  assign word_end      = out_fire && cnt_last;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign serial_sig = shift_buf[WIDTH-1 -: LANE];
      assign shifted    = shift_buf << LANE;
    end else begin : g_lsb
      assign serial_sig = shift_buf[LANE-1:0];
      assign shifted    = shift_buf >> LANE;
    end
  endgenerate

  p2s_beat_counter #(
    .CW    (CW),
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .inc       (out_fire && !cnt_last),
    .clear     (in_fire || word_end),
    .is_last   (cnt_last)
  );

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      state     <= P2S_IDLE;
      shift_buf <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        P2S_IDLE: begin
          if (in_fire) begin
            shift_buf <= parallel_sig;
            valid_q   <= 1'b1;
            state     <= P2S_SHIFT;
          end
        end
        P2S_SHIFT: begin
          if (out_fire) begin
            if (!cnt_last) begin
              shift_buf <= shifted;
            end else if (in_fire) begin
              // Next word follows the last beat with no bubble.
              shift_buf <= parallel_sig;
            end else begin
              valid_q <= 1'b0;
              state   <= P2S_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= P2S_IDLE;
        end
      endcase
    end
  end

`ifdef P2S_UNDERRUN_EN
  logic word_seen;

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      word_seen        <= 1'b0;
      underrun_sig     <= 1'b0;
      underrun_cnt_sig <= 8'd0;
    end else begin
      if (word_end) begin
        word_seen <= 1'b1;
      end
      // Downstream was ready but we had nothing to send.
      if ((state == P2S_IDLE) && out_ready_sig && word_seen) begin
        underrun_sig <= 1'b1;
        if (underrun_cnt_sig != 8'hFF) begin
          underrun_cnt_sig <= underrun_cnt_sig + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_p2s_stream.sv
// tb_p2s_stream -- directed self-checking bench for p2s_stream.
// Four instances cover LSB-first 2x1, MSB-first 8x2, LSB-first 8x1 and
// the single-beat 4x4 register-slice case. With P2S_UNDERRUN_EN defined
// the 2x1 instance also exercises the underrun counter.
module tb_p2s_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: WIDTH=2 LANE=1 LSB-first
  logic       a_rst, a_iv, a_or, a_ir, a_ov, a_ol;
  logic [1:0] a_par;
  logic [0:0] a_ser;
`ifdef P2S_UNDERRUN_EN
  logic       a_urun;
  logic [7:0] a_ucnt;
`endif

  // Instance B: WIDTH=8 LANE=2 MSB-first
  logic       b_rst, b_iv, b_or, b_ir, b_ov, b_ol;
  logic [7:0] b_par;
  logic [1:0] b_ser;

  // Instance C: WIDTH=8 LANE=1 LSB-first
  logic       c_rst, c_iv, c_or, c_ir, c_ov, c_ol;
  logic [7:0] c_par;
  logic [0:0] c_ser;

  // Instance D: WIDTH=4 LANE=4 (one beat per word)
  logic       d_rst, d_iv, d_or, d_ir, d_ov, d_ol;
  logic [3:0] d_par;
  logic [3:0] d_ser;

  p2s_stream #(.WIDTH(2), .LANE(1), .MSB_FIRST(0)) u_a (
    .clk_sig(clk), .reset_sig(a_rst), .parallel_sig(a_par),
    .in_valid_sig(a_iv), .in_ready_sig(a_ir), .serial_sig(a_ser),
    .out_valid_sig(a_ov), .out_ready_sig(a_or), .out_last_sig(a_ol)
`ifdef P2S_UNDERRUN_EN
    , .underrun_sig(a_urun), .underrun_cnt_sig(a_ucnt)
`endif
  );

  p2s_stream #(.WIDTH(8), .LANE(2), .MSB_FIRST(1)) u_b (
    .clk_sig(clk), .reset_sig(b_rst), .parallel_sig(b_par),
    .in_valid_sig(b_iv), .in_ready_sig(b_ir), .serial_sig(b_ser),
    .out_valid_sig(b_ov), .out_ready_sig(b_or), .out_last_sig(b_ol)
  );

  p2s_stream #(.WIDTH(8), .LANE(1), .MSB_FIRST(0)) u_c (
    .clk_sig(clk), .reset_sig(c_rst), .parallel_sig(c_par),
    .in_valid_sig(c_iv), .in_ready_sig(c_ir), .serial_sig(c_ser),
    .out_valid_sig(c_ov), .out_ready_sig(c_or), .out_last_sig(c_ol)
  );

  p2s_stream #(.WIDTH(4), .LANE(4), .MSB_FIRST(0)) u_d (
    .clk_sig(clk), .reset_sig(d_rst), .parallel_sig(d_par),
    .in_valid_sig(d_iv), .in_ready_sig(d_ir), .serial_sig(d_ser),
    .out_valid_sig(d_ov), .out_ready_sig(d_or), .out_last_sig(d_ol)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 0; b_rst = 0; c_rst = 0; d_rst = 0;
    a_iv = 1; b_iv = 1; c_iv = 1; d_iv = 1;
    a_or = 1; b_or = 1; c_or = 1; d_or = 1;
    a_par = 2'b11; b_par = 8'hFF; c_par = 8'hFF; d_par = 4'hF;
    step();
    step();
    vectors++;
    if ({a_ov, b_ov, c_ov, d_ov} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b exp=0000", {a_ov, b_ov, c_ov, d_ov});
    end
    vectors++;
    if ({a_ir, b_ir, c_ir, d_ir} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=0000", {a_ir, b_ir, c_ir, d_ir});
    end
    vectors++;
    if ({a_ol, b_ol, c_ol, d_ol} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_out_last got=%b exp=0000", {a_ol, b_ol, c_ol, d_ol});
    end
    vectors++;
    if ({a_ser, b_ser, c_ser, d_ser} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_serial got=%h exp=00", {a_ser, b_ser, c_ser, d_ser});
    end
    a_iv = 0; b_iv = 0; c_iv = 0; d_iv = 0;
    a_rst = 1; b_rst = 1; c_rst = 1; d_rst = 1;
    #1;
    vectors++;
    if ({a_ir, b_ir, c_ir, d_ir} !== 4'b1111) begin
      miscompares++;
      $display("FAIL idle_in_ready got=%b exp=1111", {a_ir, b_ir, c_ir, d_ir});
    end
  endtask

  task automatic test_lsb_w2();
    a_par = 2'b10; a_iv = 1; a_or = 1;
    step();
    a_iv = 0; a_par = 2'b01;
    vectors++;
    if ({a_ov, a_ser, a_ol, a_ir} !== 4'b1000) begin
      miscompares++;
      $display("FAIL w2_beat0 {ov,ser,last,ir} got=%b exp=1000", {a_ov, a_ser, a_ol, a_ir});
    end
    step();
    vectors++;
    if ({a_ov, a_ser, a_ol, a_ir} !== 4'b1111) begin
      miscompares++;
      $display("FAIL w2_beat1 {ov,ser,last,ir} got=%b exp=1111", {a_ov, a_ser, a_ol, a_ir});
    end
    step();
    vectors++;
    if ({a_ov, a_ol} !== 2'b00) begin
      miscompares++;
      $display("FAIL w2_idle {ov,last} got=%b exp=00", {a_ov, a_ol});
    end
  endtask

`ifdef P2S_UNDERRUN_EN
  // Runs straight after test_lsb_w2: A has just finished a word, a_or=1.
  task automatic test_underrun();
    vectors++;
    if ({a_urun, a_ucnt} !== 9'd0) begin
      miscompares++;
      $display("FAIL underrun_start got=%b/%0d exp=0/0", a_urun, a_ucnt);
    end
    for (int i = 0; i < 3; i++) step();
    a_or = 0;
    step();
    vectors++;
    if (a_urun !== 1'b1 || a_ucnt !== 8'd3) begin
      miscompares++;
      $display("FAIL underrun_three got=%b/%0d exp=1/3", a_urun, a_ucnt);
    end
    a_or = 1;
    for (int i = 0; i < 297; i++) step();
    vectors++;
    if (a_urun !== 1'b1 || a_ucnt !== 8'd255) begin
      miscompares++;
      $display("FAIL underrun_saturate got=%b/%0d exp=1/255", a_urun, a_ucnt);
    end
    a_rst = 0;
    step();
    a_rst = 1;
    vectors++;
    if ({a_urun, a_ucnt} !== 9'd0) begin
      miscompares++;
      $display("FAIL underrun_clear got=%b/%0d exp=0/0", a_urun, a_ucnt);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [1:0] exp1 [4];
    logic [1:0] exp2 [4];
    exp1 = '{2'd2, 2'd3, 2'd1, 2'd0};
    exp2 = '{2'd0, 2'd1, 2'd3, 2'd2};
    b_par = 8'hB4; b_iv = 1; b_or = 1;
    step();
    b_par = 8'h1E;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b_ov !== 1'b1 || b_ser !== exp1[i] || b_ol !== (i == 3) || b_ir !== (i == 3)) begin
        miscompares++;
        $display("FAIL b2b_w1_beat%0d {ov,ser,last,ir} got=%b,%0d,%b,%b exp=1,%0d,%b,%b",
                 i, b_ov, b_ser, b_ol, b_ir, exp1[i], (i == 3), (i == 3));
      end
      step();
    end
    b_iv = 0; b_par = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b_ov !== 1'b1 || b_ser !== exp2[i] || b_ol !== (i == 3)) begin
        miscompares++;
        $display("FAIL b2b_w2_beat%0d {ov,ser,last} got=%b,%0d,%b exp=1,%0d,%b",
                 i, b_ov, b_ser, b_ol, exp2[i], (i == 3));
      end
      step();
    end
    vectors++;
    if (b_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle out_valid got=%b exp=0", b_ov);
    end
  endtask

  task automatic test_stall();
    logic [0:0] bits [8];
    logic       pat  [4];
    int         k;
    bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    c_par = 8'h5A; c_iv = 1; c_or = 0;
    step();
    c_iv = 0; c_par = 8'hFF;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      c_or = pat[cyc % 4];
      #1;
      vectors++;
      if (c_ov !== 1'b1 || c_ser !== bits[k] || c_ol !== (k == 7)) begin
        miscompares++;
        $display("FAIL stall_cyc%0d {ov,ser,last} got=%b,%b,%b exp=1,%b,%b",
                 cyc, c_ov, c_ser, c_ol, bits[k], (k == 7));
      end
      step();
      if (pat[cyc % 4]) k++;
    end
    vectors++;
    if (k != 8) begin
      miscompares++;
      $display("FAIL stall_timeout beats=%0d exp=8", k);
    end
    c_or = 0;
    vectors++;
    if (c_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle out_valid got=%b exp=0", c_ov);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [0:0] bits [8];
    bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    c_par = 8'hC7; c_iv = 1; c_or = 1;
    step();
    c_iv = 0;
    step();
    step();
    vectors++;
    if (c_ov !== 1'b1 || c_ser !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_beat2 {ov,ser} got=%b,%b exp=1,1", c_ov, c_ser);
    end
    c_rst = 0;
    step();
    vectors++;
    if ({c_ov, c_ser, c_ir, c_ol} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_held {ov,ser,ir,last} got=%b exp=0000", {c_ov, c_ser, c_ir, c_ol});
    end
    c_rst = 1;
    #1;
    vectors++;
    if (c_ir !== 1'b1 || c_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_release {ir,ov} got=%b,%b exp=1,0", c_ir, c_ov);
    end
    c_par = 8'h81; c_iv = 1;
    step();
    c_iv = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (c_ov !== 1'b1 || c_ser !== bits[i] || c_ol !== (i == 7)) begin
        miscompares++;
        $display("FAIL midrst_fresh_beat%0d {ov,ser,last} got=%b,%b,%b exp=1,%b,%b",
                 i, c_ov, c_ser, c_ol, bits[i], (i == 7));
      end
      step();
    end
    vectors++;
    if (c_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle out_valid got=%b exp=0", c_ov);
    end
  endtask

  task automatic test_single_beat();
    logic [3:0] words [3];
    words = '{4'd1, 4'd2, 4'd3};
    d_par = words[0]; d_iv = 1; d_or = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (d_ov !== 1'b1 || d_ol !== 1'b1 || d_ir !== 1'b1 || d_ser !== words[i]) begin
        miscompares++;
        $display("FAIL single_word%0d {ov,last,ir,ser} got=%b,%b,%b,%0d exp=1,1,1,%0d",
                 i, d_ov, d_ol, d_ir, d_ser, words[i]);
      end
      if (i < 2) d_par = words[i + 1];
      else d_iv = 0;
      step();
    end
    vectors++;
    if (d_ov !== 1'b0 || d_ol !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle {ov,last} got=%b,%b exp=0,0", d_ov, d_ol);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_w2();
`ifdef P2S_UNDERRUN_EN
    test_underrun();
`endif
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_single_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
